// File: rtl/dmem_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module      : dmem_arbiter_pkg
// Description : State encodings and master IDs shared by the data-memory arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`define DMEM_ARB_ST_ARB   2'd0
`define DMEM_ARB_ST_LOCK0 2'd1
`define DMEM_ARB_ST_LOCK1 2'd2

package dmem_arbiter_pkg;

   localparam logic MASTER_CPU = 1'b0;
   localparam logic MASTER_AUX = 1'b1;

   typedef enum logic [1:0] {
      ST_ARB   = `DMEM_ARB_ST_ARB,
      ST_LOCK0 = `DMEM_ARB_ST_LOCK0,
      ST_LOCK1 = `DMEM_ARB_ST_LOCK1
   } arb_state_e;

endpackage : dmem_arbiter_pkg

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : dmem_arbiter_if
// Description : Bundle of both master ports and the memory-side port.
//               DMEM_ARB_STATS_EN adds the grant/forced-release counter outputs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_arbiter_if #(
   parameter int unsigned DBITS         = 32,
   parameter int unsigned DMEMINDEXBITS = 11
);

   logic                     m0_req;
   logic                     m0_wrtEn;
   logic                     m0_lock;
   logic [DMEMINDEXBITS-1:0] m0_index;
   logic [DBITS-1:0]         m0_dataIn;
   logic                     m0_gnt;
   logic                     m0_rdValid;
   logic [DBITS-1:0]         m0_dataOut;

   logic                     m1_req;
   logic                     m1_wrtEn;
   logic                     m1_lock;
   logic [DMEMINDEXBITS-1:0] m1_index;
   logic [DBITS-1:0]         m1_dataIn;
   logic                     m1_gnt;
   logic                     m1_rdValid;
   logic [DBITS-1:0]         m1_dataOut;

   logic                     mem_wrtEn;
   logic [DMEMINDEXBITS-1:0] mem_index;
   logic [DBITS-1:0]         mem_dataIn;
   logic [DBITS-1:0]         mem_dataOut;

`ifdef DMEM_ARB_STATS_EN
   logic [31:0]              m0_grantCnt;
   logic [31:0]              m1_grantCnt;
   logic [15:0]              forceRelCnt;
`endif

   // Arbiter side
   modport slave (
      input  m0_req, m0_wrtEn, m0_lock, m0_index, m0_dataIn,
      output m0_gnt, m0_rdValid, m0_dataOut,
      input  m1_req, m1_wrtEn, m1_lock, m1_index, m1_dataIn,
      output m1_gnt, m1_rdValid, m1_dataOut,
      output mem_wrtEn, mem_index, mem_dataIn,
      input  mem_dataOut
`ifdef DMEM_ARB_STATS_EN
      ,
      output m0_grantCnt, m1_grantCnt, forceRelCnt
`endif
   );

   // Requesters and memory side
   modport master (
      output m0_req, m0_wrtEn, m0_lock, m0_index, m0_dataIn,
      input  m0_gnt, m0_rdValid, m0_dataOut,
      output m1_req, m1_wrtEn, m1_lock, m1_index, m1_dataIn,
      input  m1_gnt, m1_rdValid, m1_dataOut,
      input  mem_wrtEn, mem_index, mem_dataIn,
      output mem_dataOut
`ifdef DMEM_ARB_STATS_EN
      ,
      input  m0_grantCnt, m1_grantCnt, forceRelCnt
`endif
   );

endinterface : dmem_arbiter_if

`default_nettype wire

// File: rtl/dmem_arb_rr_pick.sv
//------------------------------------------------------------------------------
// Module      : dmem_arb_rr_pick
// Description : Two-way combinational round-robin selector with lock mask.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arb_rr_pick
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       lastGrant_i,
   input  logic [1:0] lockMask_i,
   output logic [1:0] gnt_o
);

   logic [1:0] eligible;

   always_comb begin
      gnt_o    = 2'b00;
      eligible = req_i & lockMask_i;
      unique case (eligible)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         // On a tie the master that was not served last wins
         2'b11:   gnt_o = (lastGrant_i == MASTER_CPU) ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule : dmem_arb_rr_pick

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : dmem_arbiter
// Description : Round-robin arbiter with bounded lock sharing one data memory
//               between two masters. DMEM_ARB_STATS_EN enables grant counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned DBITS         = 32,
   parameter int unsigned DMEMINDEXBITS = 11,
   parameter int unsigned LOCK_MAX      = 8
)(
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   localparam int unsigned     CW         = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0]   LOCK_MAX_C = CW'(LOCK_MAX);
   localparam logic [CW-1:0]   LOCK_ONE   = CW'(1);

   arb_state_e    state_q, state_d;
   logic          lastGrant_q, lastGrant_d;
   logic [CW-1:0] lockCnt_q, lockCnt_d;
   logic [1:0]    rdPend_q, rdPend_d;

   logic [1:0]    lockMask;
   logic [1:0]    pickGnt;
   logic [1:0]    gnt;

   dmem_arb_rr_pick u_pick (
      .req_i       ({bus.m1_req, bus.m0_req}),
      .lastGrant_i (lastGrant_q),
      .lockMask_i  (lockMask),
      .gnt_o       (pickGnt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_ARB;
         lastGrant_q <= MASTER_AUX;
         lockCnt_q   <= '0;
         rdPend_q    <= '0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         lockCnt_q   <= lockCnt_d;
         rdPend_q    <= rdPend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      lockCnt_d   = lockCnt_q;
      lockMask    = 2'b11;

      unique case (state_q)
         ST_LOCK0: lockMask = 2'b01;
         ST_LOCK1: lockMask = 2'b10;
         default:  lockMask = 2'b11;
      endcase

      // Nothing is issued while reset is held, including writes
      gnt = reset ? 2'b00 : pickGnt;

      if (gnt[0]) lastGrant_d = MASTER_CPU;
      if (gnt[1]) lastGrant_d = MASTER_AUX;

      unique case (state_q)
         ST_ARB: begin
            lockCnt_d = '0;
            if (gnt[0] && bus.m0_lock) begin
               state_d   = ST_LOCK0;
               lockCnt_d = LOCK_ONE;
            end else if (gnt[1] && bus.m1_lock) begin
               state_d   = ST_LOCK1;
               lockCnt_d = LOCK_ONE;
            end
         end
         ST_LOCK0: begin
            if (!bus.m0_lock || lockCnt_q == LOCK_MAX_C) begin
               state_d     = ST_ARB;
               lockCnt_d   = '0;
               lastGrant_d = MASTER_CPU;
            end else begin
               lockCnt_d = lockCnt_q + LOCK_ONE;
            end
         end
         ST_LOCK1: begin
            if (!bus.m1_lock || lockCnt_q == LOCK_MAX_C) begin
               state_d     = ST_ARB;
               lockCnt_d   = '0;
               lastGrant_d = MASTER_AUX;
            end else begin
               lockCnt_d = lockCnt_q + LOCK_ONE;
            end
         end
         default: begin
            state_d   = ST_ARB;
            lockCnt_d = '0;
         end
      endcase

      rdPend_d = gnt & ~{bus.m1_wrtEn, bus.m0_wrtEn};
   end

   always_comb begin
      bus.mem_wrtEn  = 1'b0;
      bus.mem_index  = {DMEMINDEXBITS{1'b0}};
      bus.mem_dataIn = {DBITS{1'b0}};
      if (gnt[0]) begin
         bus.mem_wrtEn  = bus.m0_wrtEn;
         bus.mem_index  = bus.m0_index;
         bus.mem_dataIn = bus.m0_dataIn;
      end else if (gnt[1]) begin
         bus.mem_wrtEn  = bus.m1_wrtEn;
         bus.mem_index  = bus.m1_index;
         bus.mem_dataIn = bus.m1_dataIn;
      end
   end

   assign bus.m0_gnt     = gnt[0];
   assign bus.m1_gnt     = gnt[1];
   // A read pending across a reset edge is dropped here and by the register clear
   assign bus.m0_rdValid = rdPend_q[0] & ~reset;
   assign bus.m1_rdValid = rdPend_q[1] & ~reset;
   assign bus.m0_dataOut = bus.mem_dataOut;
   assign bus.m1_dataOut = bus.mem_dataOut;

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] m0GrantCnt_q;
   logic [31:0] m1GrantCnt_q;
   logic [15:0] forceRelCnt_q;
   logic        forceRel;

   assign forceRel = !reset && (lockCnt_q == LOCK_MAX_C) &&
                     ((state_q == ST_LOCK0 && bus.m0_lock) ||
                      (state_q == ST_LOCK1 && bus.m1_lock));

   always_ff @(posedge clk) begin
      if (reset) begin
         m0GrantCnt_q  <= '0;
         m1GrantCnt_q  <= '0;
         forceRelCnt_q <= '0;
      end else begin
         if (gnt[0]) m0GrantCnt_q <= m0GrantCnt_q + 32'd1;
         if (gnt[1]) m1GrantCnt_q <= m1GrantCnt_q + 32'd1;
         if (forceRel && forceRelCnt_q != 16'hFFFF)
            forceRelCnt_q <= forceRelCnt_q + 16'd1;
      end
   end

   assign bus.m0_grantCnt = m0GrantCnt_q;
   assign bus.m1_grantCnt = m1GrantCnt_q;
   assign bus.forceRelCnt = forceRelCnt_q;
`endif

endmodule : dmem_arbiter

`default_nettype wire
